// File: rtl/sd_dfc_pkg.sv
// Shared delayed-flow-control definitions used by both ends of the link (sd_dfc_tx / sd_dfc_rx).
package sd_dfc_pkg;

    localparam logic dfc_fc_go   = 1'b1;
    localparam logic dfc_fc_stop = 1'b0;

    // Cycles the transmitter adds to the link round-trip (the fc capture flop)
    localparam int unsigned dfc_tx_lat = 1;

    localparam int unsigned skid_depth = 2;

    typedef logic [1:0] skid_occ_t;

endpackage

// File: rtl/sd_dfc_tx_skid.sv
// Two-entry skid buffer feeding the DFC transmitter; c_drdy is registered from next occupancy.
module sd_dfc_tx_skid
    import sd_dfc_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [width-1:0] c_data,
    input  logic             pop,
    output logic [width-1:0] head,
    output skid_occ_t        occ
);

    logic [width-1:0] mem [skid_depth];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    skid_occ_t        occ_nxt;

    assign push = c_srdy & c_drdy;
    assign head = mem[rd_ptr];

    always_comb begin
        occ_nxt = occ + skid_occ_t'(push) - skid_occ_t'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            c_drdy <= 1'b0;
        end else begin
            occ    <= occ_nxt;
            c_drdy <= (occ_nxt != skid_occ_t'(skid_depth));
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // Storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= c_data;
    end

endmodule

// File: rtl/sd_dfc_tx.sv
// Delayed-flow-control transmitter: registered valid/data link paced by a captured p_fc_n.
// Optional stall counter enabled by defining SD_DFC_TX_STALL_CNT_EN.
module sd_dfc_tx
    import sd_dfc_pkg::*;
#(
    parameter int unsigned width  = 8,
    parameter int unsigned cnt_sz = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_srdy,
    output logic              c_drdy,
    input  logic [width-1:0]  c_data,
    output logic              p_vld,
    output logic [width-1:0]  p_data,
    input  logic              p_fc_n,
    input  logic              force_stop,
    input  logic              stall_clr,
    output logic [cnt_sz-1:0] stall_cnt
);

    logic             fc_q;
    logic             send;
    logic [width-1:0] head;
    skid_occ_t        occ;

    sd_dfc_tx_skid #(.width(width)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .c_srdy (c_srdy),
        .c_drdy (c_drdy),
        .c_data (c_data),
        .pop    (send),
        .head   (head),
        .occ    (occ)
    );

    assign send = (fc_q == dfc_fc_go) && (occ != '0);

    // Flow-control capture and link output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fc_q   <= dfc_fc_stop;
            p_vld  <= 1'b0;
            p_data <= '0;
        end else begin
            fc_q  <= p_fc_n & ~force_stop;
            p_vld <= send;
            if (send) p_data <= head;
        end
    end

`ifdef SD_DFC_TX_STALL_CNT_EN
    logic stall;

    assign stall = (occ != '0) && (fc_q == dfc_fc_stop);

    // Saturating stall counter; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst || stall_clr) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + cnt_sz'(1);
        end
    end
`else
    logic unused_stall_clr;

    assign unused_stall_clr = stall_clr;
    assign stall_cnt        = '0;
`endif

endmodule
